// File: rtl/enemy_fire_scheduler_if.sv
// Bus between the level/enemy logic and the shared enemy-missile fire scheduler.
// The master drives enemy requests and slot releases; the slave returns grants and slot state.
interface enemy_fire_scheduler_if #(
   parameter int unsigned NE    = 16,
   parameter int unsigned NSLOT = 4
);
   localparam int unsigned SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   logic             frame_tick;
   logic             enable;
   logic             reset_ships;
   logic [2:0]       current_level;
   logic [NE-1:0]    eship_en;
   logic [NE-1:0]    fire_req;
   logic [NSLOT-1:0] msl_done;
   logic [NE-1:0]    fire_grant;
   logic [SW-1:0]    grant_slot;
   logic [NSLOT-1:0] slot_busy;
   logic [7:0]       shot_count;

   modport master (
      output frame_tick, enable, reset_ships, current_level, eship_en, fire_req, msl_done,
      input  fire_grant, grant_slot, slot_busy, shot_count
   );

   modport slave (
      input  frame_tick, enable, reset_ships, current_level, eship_en, fire_req, msl_done,
      output fire_grant, grant_slot, slot_busy, shot_count
   );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Paces enemy fire: a level-dependent frame cooldown, then a round-robin pick among
// live requesting enemies, each shot bound to the lowest free missile slot.
module enemy_fire_scheduler #(
   parameter int unsigned NE    = 16,
   parameter int unsigned NSLOT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   enemy_fire_scheduler_if.slave bus
);
   localparam int unsigned WW = (NE > 1) ? $clog2(NE) : 1;
   localparam int unsigned SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE, COOLDOWN, ARB, GRANT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NSLOT-1:0] busy_q, busy_d;
   logic [WW-1:0]    last_q, last_d;
   logic [7:0]       shot_q, shot_d;
   logic [WW-1:0]    win_q;
   logic [SW-1:0]    slot_q;
   logic [NE-1:0]    grant_q;

   logic [NE-1:0]    valid_c;
   logic [WW-1:0]    win_c;
   logic             win_found_c;
   logic [SW-1:0]    slot_c;
   logic             slot_free_c;
   logic [CW-1:0]    reload_c;
   logic             take_c;

   // Round-robin winner after the last shooter, and lowest free slot
   always_comb begin
      int unsigned idx;
      valid_c     = bus.fire_req & bus.eship_en;
      win_c       = last_q;
      win_found_c = 1'b0;
      idx         = 0;
      for (int unsigned k = 1; k <= NE; k++) begin
         idx = 32'(last_q) + k;
         if (idx >= NE) idx = idx - NE;
         if (!win_found_c && valid_c[WW'(idx)]) begin
            win_c       = WW'(idx);
            win_found_c = 1'b1;
         end
      end
      slot_c      = '0;
      slot_free_c = 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
         if (!slot_free_c && !busy_q[SW'(i)]) begin
            slot_c      = SW'(i);
            slot_free_c = 1'b1;
         end
      end
   end

   // Cooldown length in frames; later levels shoot more often
   always_comb begin
      case (bus.current_level)
         3'd0:    reload_c = CW'(48);
         3'd1:    reload_c = CW'(32);
         default: reload_c = CW'(16);
      endcase
   end

   // Next state; ResetShips outranks Enable, which outranks normal sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      take_c  = 1'b0;
      busy_d  = busy_q & ~bus.msl_done;
      last_d  = last_q;
      shot_d  = shot_q;
      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               state_d = COOLDOWN;
               cnt_d   = reload_c;
            end
         end
         COOLDOWN: begin
            if (cnt_q == '0)         state_d = ARB;
            else if (bus.frame_tick) cnt_d   = cnt_q - CW'(1);
         end
         ARB: begin
            if (valid_c != '0 && slot_free_c) begin
               state_d = GRANT;
               take_c  = 1'b1;
            end
         end
         GRANT: begin
            state_d        = COOLDOWN;
            cnt_d          = reload_c;
            busy_d[slot_q] = 1'b1;
            last_d         = win_q;
            if (shot_q != 8'hFF) shot_d = shot_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
      if (!bus.enable) begin
         state_d = IDLE;
         take_c  = 1'b0;
      end
      if (bus.reset_ships) begin
         state_d = IDLE;
         take_c  = 1'b0;
         cnt_d   = '0;
         busy_d  = '0;
         last_d  = WW'(NE - 1);
         shot_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= '0;
         last_q  <= WW'(NE - 1);
         shot_q  <= '0;
         win_q   <= '0;
         slot_q  <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         shot_q  <= shot_d;
         grant_q <= '0;
         if (take_c) begin
            win_q   <= win_c;
            slot_q  <= slot_c;
            grant_q <= NE'(1) << win_c;
         end
      end
   end

   assign bus.fire_grant = grant_q;
   assign bus.grant_slot = slot_q;
   assign bus.slot_busy  = busy_q;
   assign bus.shot_count = shot_q;
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler: cooldown timing, round-robin order,
// slot allocation, ResetShips/Enable overrides and asynchronous reset.
module tb_enemy_fire_scheduler;
   localparam int unsigned NE    = 16;
   localparam int unsigned NSLOT = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   errors  = 0;
   int   checks  = 0;
   int   cyc;
   int   seen;

   enemy_fire_scheduler_if #(.NE(NE), .NSLOT(NSLOT)) bus ();

   enemy_fire_scheduler #(.NE(NE), .NSLOT(NSLOT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clock until a grant appears or the budget runs out; returns cycles taken
   task automatic wait_grant(input string tag, input int maxc, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.fire_grant == '0 && n < maxc);
      check({tag, "_seen"}, 32'(bus.fire_grant != '0), 32'd1);
      check({tag, "_onehot"}, 32'($countones(bus.fire_grant)), 32'd1);
   endtask

   task automatic reset_ships_pulse();
      bus.reset_ships = 1'b1;
      step();
      bus.reset_ships = 1'b0;
   endtask

   initial begin
      bus.frame_tick    = 1'b1;
      bus.enable        = 1'b0;
      bus.reset_ships   = 1'b0;
      bus.current_level = 3'd0;
      bus.eship_en      = '0;
      bus.fire_req      = '0;
      bus.msl_done      = '0;

      #12;
      check("rst_grant", 32'(bus.fire_grant), 32'h0);
      check("rst_slot",  32'(bus.grant_slot), 32'h0);
      check("rst_busy",  32'(bus.slot_busy),  32'h0);
      check("rst_shots", 32'(bus.shot_count), 32'h0);

      // First shot at level 0: load edge, 48 ticks, then ARB and GRANT
      step();
      bus.enable   = 1'b1;
      bus.eship_en = 16'hFFFF;
      bus.fire_req = 16'h0001;
      reset_n      = 1'b1;
      wait_grant("l0_first", 200, cyc);
      check("l0_latency", 32'(cyc), 32'd51);
      check("l0_grant",   32'(bus.fire_grant), 32'h0001);
      check("l0_slot",    32'(bus.grant_slot), 32'h0);
      step();
      check("l0_grant_drop", 32'(bus.fire_grant), 32'h0);
      check("l0_busy",       32'(bus.slot_busy),  32'h1);
      check("l0_shots",      32'(bus.shot_count), 32'd1);

      // Round robin, all requesting at level 2, slot freed after each shot
      bus.current_level = 3'd2;
      bus.fire_req      = 16'hFFFF;
      reset_ships_pulse();
      check("rs_busy",  32'(bus.slot_busy),  32'h0);
      check("rs_shots", 32'(bus.shot_count), 32'h0);
      for (int n = 0; n < 17; n++) begin
         wait_grant("rr", 100, cyc);
         check("rr_spacing", 32'(cyc), (n == 0) ? 32'd19 : 32'd17);
         check("rr_winner",  32'(bus.fire_grant), 32'(1) << (n % 16));
         check("rr_slot",    32'(bus.grant_slot), 32'h0);
         step();
         bus.msl_done = 4'b0001;
         step();
         bus.msl_done = '0;
      end
      check("rr_shots", 32'(bus.shot_count), 32'd17);
      check("rr_busy",  32'(bus.slot_busy),  32'h0);

      // Level 1 spacing, then an out-of-range level behaves as level 2
      bus.current_level = 3'd1;
      bus.fire_req      = 16'h0001;
      reset_ships_pulse();
      wait_grant("l1", 100, cyc);
      check("l1_spacing", 32'(cyc), 32'd35);
      check("l1_winner",  32'(bus.fire_grant), 32'h0001);
      bus.current_level = 3'd5;
      step();
      bus.msl_done = 4'b0001;
      step();
      bus.msl_done = '0;
      wait_grant("l5", 100, cyc);
      check("l5_spacing", 32'(cyc), 32'd17);

      // Fill all four slots with a single requester, then starve in ARB
      bus.current_level = 3'd2;
      bus.fire_req      = 16'h0020;
      reset_ships_pulse();
      for (int k = 0; k < 4; k++) begin
         wait_grant("fill", 100, cyc);
         check("fill_spacing", 32'(cyc), (k == 0) ? 32'd19 : 32'd18);
         check("fill_winner",  32'(bus.fire_grant), 32'h0020);
         check("fill_slot",    32'(bus.grant_slot), 32'(k));
         step();
      end
      check("full_busy",  32'(bus.slot_busy),  32'hF);
      check("full_shots", 32'(bus.shot_count), 32'd4);
      seen = 0;
      repeat (40) begin
         step();
         if (bus.fire_grant != '0) seen++;
      end
      check("full_no_grant", 32'(seen), 32'd0);
      bus.msl_done = 4'b0100;
      step();
      bus.msl_done = '0;
      check("free2_busy",  32'(bus.slot_busy),  32'hB);
      check("free2_grant", 32'(bus.fire_grant), 32'h0);
      step();
      check("free2_winner", 32'(bus.fire_grant), 32'h0020);
      check("free2_slot",   32'(bus.grant_slot), 32'd2);

      // ResetShips during cooldown clears slots and shot count
      step();
      check("refill_busy", 32'(bus.slot_busy), 32'hF);
      bus.msl_done = 4'b0100;
      step();
      bus.msl_done = '0;
      check("cd_busy", 32'(bus.slot_busy), 32'hB);
      reset_ships_pulse();
      check("cd_rs_busy",  32'(bus.slot_busy),  32'h0);
      check("cd_rs_shots", 32'(bus.shot_count), 32'h0);
      check("cd_rs_grant", 32'(bus.fire_grant), 32'h0);

      // Enable drop while waiting in ARB keeps slots and count
      bus.fire_req = 16'h0008;
      wait_grant("en", 100, cyc);
      check("en_spacing", 32'(cyc), 32'd19);
      check("en_winner",  32'(bus.fire_grant), 32'h0008);
      step();
      bus.fire_req = '0;
      repeat (25) step();
      bus.enable   = 1'b0;
      bus.fire_req = 16'h0008;
      step();
      check("dis_grant", 32'(bus.fire_grant), 32'h0);
      check("dis_busy",  32'(bus.slot_busy),  32'h1);
      check("dis_shots", 32'(bus.shot_count), 32'd1);
      seen = 0;
      repeat (5) begin
         step();
         if (bus.fire_grant != '0) seen++;
      end
      check("dis_idle_no_grant", 32'(seen), 32'd0);
      bus.enable = 1'b1;
      wait_grant("reen", 100, cyc);
      check("reen_spacing", 32'(cyc), 32'd19);
      check("reen_winner",  32'(bus.fire_grant), 32'h0008);
      check("reen_slot",    32'(bus.grant_slot), 32'd1);

      // Winner dying after arbitration does not cancel its shot
      step();
      repeat (17) step();
      step();
      bus.eship_en = '0;
      #1;
      check("die_grant", 32'(bus.fire_grant), 32'h0008);
      check("die_slot",  32'(bus.grant_slot), 32'd2);
      step();
      bus.eship_en = 16'hFFFF;
      check("die_shots", 32'(bus.shot_count), 32'd3);
      check("die_busy",  32'(bus.slot_busy),  32'h7);

      // Asynchronous reset in the middle of a grant
      wait_grant("async", 100, cyc);
      check("async_spacing", 32'(cyc), 32'd18);
      check("async_slot",    32'(bus.grant_slot), 32'd3);
      reset_n = 1'b0;
      #1;
      check("async_grant", 32'(bus.fire_grant), 32'h0);
      check("async_busy",  32'(bus.slot_busy),  32'h0);
      check("async_shots", 32'(bus.shot_count), 32'h0);
      check("async_gslot", 32'(bus.grant_slot), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
